// File: rtl/fifo_depth_n_if.sv
// Enqueue/dequeue method bundle for fifo_depth_n, parameterised by payload width.
// Field mapping: enq_ena/enq_v/enq_rdy = in$enq__ENA/$v/__RDY; deq_ena/deq_rdy = out$deq__ENA/__RDY;
// first/first_rdy = out$first/out$first__RDY.
interface fifo_depth_n_if #(
  parameter int WIDTH = 32
) ();
  // Handshake: a method fires on a rising CLK edge where its __ENA and __RDY are both high;
  // raising __ENA while __RDY is low is a protocol violation and the strobe is dropped.
  logic             enq_ena;
  logic [WIDTH-1:0] enq_v;
  logic             enq_rdy;
  logic             deq_ena;
  logic             deq_rdy;
  logic [WIDTH-1:0] first;
  logic             first_rdy;

  modport master (
    output enq_ena, enq_v, deq_ena,
    input  enq_rdy, deq_rdy, first, first_rdy
  );

  modport slave (
    input  enq_ena, enq_v, deq_ena,
    output enq_rdy, deq_rdy, first, first_rdy
  );
endinterface

// File: rtl/fifo_depth_n.sv
// DEPTH-entry guarded FIFO with occupancy count, almost-full and sticky protocol-error flag.
// Optional macro FIFO_FULL_PASS_EN: accept an enq while full when a deq fires in the same cycle.
module fifo_depth_n #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  fifo_depth_n_if.slave                io,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Levels above DEPTH can never be reached; clamp so the threshold fits CNT_W+1 bits.
  localparam int AF_CLAMP = (AFULL_LEVEL > DEPTH) ? DEPTH + 1 : AFULL_LEVEL;
  localparam logic [CNT_W:0] AF_THRESH = (CNT_W + 1)'(AF_CLAMP);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] cnt;

  logic empty;
  logic full;
  logic enq_fire;
  logic deq_fire;
  logic violation;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    else                        return p + PTR_W'(1);
  endfunction

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

`ifdef FIFO_FULL_PASS_EN
  // A deq in the same cycle frees the slot at wptr, so a full FIFO can still take data.
  assign io.enq_rdy = !full | io.deq_ena;
`else
  assign io.enq_rdy = !full;
`endif
  assign io.deq_rdy   = !empty;
  assign io.first_rdy = !empty;
  assign io.first     = empty ? '0 : mem[rptr];

  assign enq_fire  = io.enq_ena & io.enq_rdy;
  assign deq_fire  = io.deq_ena & io.deq_rdy;
  assign violation = (io.enq_ena & !io.enq_rdy) | (io.deq_ena & !io.deq_rdy);

  assign count       = cnt;
  assign almost_full = ({1'b0, cnt} >= AF_THRESH);

  // Payload storage carries no reset; empty gating keeps stale contents off the outputs.
  always_ff @(posedge CLK) begin
    if (enq_fire) mem[wptr] <= io.enq_v;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      if (enq_fire) wptr <= next_ptr(wptr);
      if (deq_fire) rptr <= next_ptr(rptr);
      case ({enq_fire, deq_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (violation) err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_cnt_range: assert property (@(posedge CLK) disable iff (RST) cnt <= CNT_W'(DEPTH));
  a_ptr_range: assert property (@(posedge CLK) disable iff (RST)
    (rptr <= PTR_W'(DEPTH - 1)) && (wptr <= PTR_W'(DEPTH - 1)));
  a_ptr_gap:   assert property (@(posedge CLK) disable iff (RST)
    ((32'(rptr) + 32'(cnt)) % 32'(DEPTH)) == 32'(wptr));
`endif

endmodule

// File: tb/tb_fifo_depth_n.sv
// Bench for fifo_depth_n: directed scenarios on DEPTH 4/3/1 instances plus a randomized run on DEPTH 4
// checked against a queue-based reference model.
module tb_fifo_depth_n;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  fifo_depth_n_if #(.WIDTH(32)) if4 ();
  fifo_depth_n_if #(.WIDTH(32)) if3 ();
  fifo_depth_n_if #(.WIDTH(32)) if1 ();

  logic [2:0] c4;
  logic [1:0] c3;
  logic [0:0] c1;
  logic       af4, af3, af1;
  logic       e4, e3, e1;

`ifdef FIFO_FULL_PASS_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  fifo_depth_n #(.WIDTH(32), .DEPTH(4)) u4 (
    .CLK(CLK), .RST(RST), .io(if4), .count(c4), .almost_full(af4), .err(e4));
  fifo_depth_n #(.WIDTH(32), .DEPTH(3), .AFULL_LEVEL(0)) u3 (
    .CLK(CLK), .RST(RST), .io(if3), .count(c3), .almost_full(af3), .err(e3));
  fifo_depth_n #(.WIDTH(32), .DEPTH(1), .AFULL_LEVEL(1)) u1 (
    .CLK(CLK), .RST(RST), .io(if1), .count(c1), .almost_full(af1), .err(e1));

  task automatic idle_all();
    if4.enq_ena = 1'b0; if4.deq_ena = 1'b0; if4.enq_v = '0;
    if3.enq_ena = 1'b0; if3.deq_ena = 1'b0; if3.enq_v = '0;
    if1.enq_ena = 1'b0; if1.deq_ena = 1'b0; if1.enq_v = '0;
  endtask

  // Called at negedge+1; applies strobes for one rising edge and returns at the next negedge+1.
  task automatic drive(input int sel, input bit e, input logic [31:0] v, input bit d);
    case (sel)
      4:       begin if4.enq_ena = e; if4.enq_v = v; if4.deq_ena = d; end
      3:       begin if3.enq_ena = e; if3.enq_v = v; if3.deq_ena = d; end
      default: begin if1.enq_ena = e; if1.enq_v = v; if1.deq_ena = d; end
    endcase
    @(posedge CLK);
    @(negedge CLK);
    idle_all();
    #1;
  endtask

  task automatic apply_reset();
    idle_all();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    RST = 1'b1;
    #1;
    checks++; if (if4.enq_rdy !== 1'b1 || if4.deq_rdy !== 1'b0 || if4.first_rdy !== 1'b0)
      begin errors++; $display("FAIL reset_rdy4 got enq=%b deq=%b fr=%b exp 1 0 0", if4.enq_rdy, if4.deq_rdy, if4.first_rdy); end
    checks++; if (if4.first !== 32'h0 || c4 !== 3'd0 || af4 !== 1'b0 || e4 !== 1'b0)
      begin errors++; $display("FAIL reset_state4 got first=%h cnt=%0d af=%b err=%b exp 0 0 0 0", if4.first, c4, af4, e4); end
    checks++; if (af3 !== 1'b1 || c3 !== 2'd0 || if3.enq_rdy !== 1'b1)
      begin errors++; $display("FAIL reset_state3 got af=%b cnt=%0d enq=%b exp 1 0 1", af3, c3, if3.enq_rdy); end
    checks++; if (af1 !== 1'b0 || c1 !== 1'b0 || e1 !== 1'b0 || if1.first_rdy !== 1'b0)
      begin errors++; $display("FAIL reset_state1 got af=%b cnt=%0d err=%b fr=%b exp 0 0 0 0", af1, c1, e1, if1.first_rdy); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4, 1'b1, vals[i], 1'b0);
      checks++; if (int'(c4) !== i + 1)
        begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, c4, i + 1); end
      checks++; if (af4 !== (i + 1 >= 3))
        begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, af4, (i + 1 >= 3)); end
      checks++; if (if4.enq_rdy !== (i < 3))
        begin errors++; $display("FAIL fill_enq_rdy[%0d] got %b exp %b", i, if4.enq_rdy, (i < 3)); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (if4.first !== vals[i] || if4.first_rdy !== 1'b1)
        begin errors++; $display("FAIL drain_first[%0d] got %h/%b exp %h/1", i, if4.first, if4.first_rdy, vals[i]); end
      drive(4, 1'b0, 32'h0, 1'b1);
    end
    checks++; if (if4.first_rdy !== 1'b0 || if4.first !== 32'h0 || c4 !== 3'd0 || e4 !== 1'b0)
      begin errors++; $display("FAIL drain_end got fr=%b first=%h cnt=%0d err=%b exp 0 0 0 0", if4.first_rdy, if4.first, c4, e4); end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive(3, 1'b1, 32'd1, 1'b0);
    drive(3, 1'b1, 32'd2, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      checks++; if (if3.first !== 32'(k))
        begin errors++; $display("FAIL wrap_first[%0d] got %0d exp %0d", k, if3.first, k); end
      drive(3, 1'b1, 32'(k + 2), 1'b1);
      checks++; if (c3 !== 2'd2)
        begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 2", k, c3); end
    end
    for (int k = 11; k <= 12; k++) begin
      checks++; if (if3.first !== 32'(k))
        begin errors++; $display("FAIL wrap_tail[%0d] got %0d exp %0d", k, if3.first, k); end
      drive(3, 1'b0, 32'h0, 1'b1);
    end
    checks++; if (c3 !== 2'd0 || e3 !== 1'b0 || af3 !== 1'b1)
      begin errors++; $display("FAIL wrap_end got cnt=%0d err=%b af=%b exp 0 0 1", c3, e3, af3); end
  endtask

  task automatic test_deq_empty();
    apply_reset();
    drive(4, 1'b1, 32'hAB, 1'b1);
    checks++; if (e4 !== 1'b1)
      begin errors++; $display("FAIL deq_empty_err got %b exp 1", e4); end
    checks++; if (c4 !== 3'd1 || if4.first !== 32'hAB || if4.first_rdy !== 1'b1)
      begin errors++; $display("FAIL deq_empty_data got cnt=%0d first=%h fr=%b exp 1 ab 1", c4, if4.first, if4.first_rdy); end
    drive(4, 1'b0, 32'h0, 1'b0);
    checks++; if (e4 !== 1'b1)
      begin errors++; $display("FAIL deq_empty_sticky got %b exp 1", e4); end
  endtask

  task automatic test_enq_full();
    logic [31:0] q [$];
    logic [31:0] v;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      q.push_back(v);
      drive(4, 1'b1, v, 1'b0);
    end
    if4.enq_ena = 1'b1; if4.enq_v = 32'h55; if4.deq_ena = 1'b1;
    #1;
    checks++; if (if4.enq_rdy !== PASS)
      begin errors++; $display("FAIL full_enq_rdy got %b exp %b", if4.enq_rdy, PASS); end
    drive(4, 1'b1, 32'h55, 1'b1);
    void'(q.pop_front());
    if (PASS) q.push_back(32'h55);
    checks++; if (int'(c4) !== q.size())
      begin errors++; $display("FAIL full_count got %0d exp %0d", c4, q.size()); end
    checks++; if (e4 !== !PASS)
      begin errors++; $display("FAIL full_err got %b exp %b", e4, !PASS); end
    while (q.size() > 0) begin
      checks++; if (if4.first !== q[0])
        begin errors++; $display("FAIL full_drain got %h exp %h", if4.first, q[0]); end
      void'(q.pop_front());
      drive(4, 1'b0, 32'h0, 1'b1);
    end
    checks++; if (c4 !== 3'd0 || if4.first_rdy !== 1'b0)
      begin errors++; $display("FAIL full_end got cnt=%0d fr=%b exp 0 0", c4, if4.first_rdy); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(4, 1'b1, 32'h1234, 1'b0);
    drive(4, 1'b1, 32'h5678, 1'b0);
    #2 RST = 1'b1;
    #1;
    checks++; if (c4 !== 3'd0 || if4.first_rdy !== 1'b0 || if4.first !== 32'h0 || if4.enq_rdy !== 1'b1 || if4.deq_rdy !== 1'b0)
      begin errors++; $display("FAIL async_reset got cnt=%0d fr=%b first=%h enq=%b deq=%b exp 0 0 0 1 0",
        c4, if4.first_rdy, if4.first, if4.enq_rdy, if4.deq_rdy); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++; if (c4 !== 3'd0 || if4.first_rdy !== 1'b0)
      begin errors++; $display("FAIL async_release got cnt=%0d fr=%b exp 0 0", c4, if4.first_rdy); end
    drive(4, 1'b1, 32'h7, 1'b0);
    checks++; if (c4 !== 3'd1 || if4.first !== 32'h7)
      begin errors++; $display("FAIL async_enq got cnt=%0d first=%h exp 1 7", c4, if4.first); end
    drive(4, 1'b0, 32'h0, 1'b1);
    checks++; if (c4 !== 3'd0 || e4 !== 1'b0)
      begin errors++; $display("FAIL async_deq got cnt=%0d err=%b exp 0 0", c4, e4); end
  endtask

  task automatic test_depth1();
    logic [31:0] vals [2];
    vals[0] = 32'hA; vals[1] = 32'hB;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      checks++; if (if1.enq_rdy !== 1'b1)
        begin errors++; $display("FAIL d1_rdy_empty[%0d] got %b exp 1", i, if1.enq_rdy); end
      drive(1, 1'b1, vals[i], 1'b0);
      checks++; if (if1.enq_rdy !== 1'b0 || if1.first !== vals[i] || c1 !== 1'b1 || af1 !== 1'b1)
        begin errors++; $display("FAIL d1_full[%0d] got rdy=%b first=%h cnt=%0d af=%b exp 0 %h 1 1",
          i, if1.enq_rdy, if1.first, c1, af1, vals[i]); end
      drive(1, 1'b0, 32'h0, 1'b1);
      checks++; if (c1 !== 1'b0 || af1 !== 1'b0 || if1.first !== 32'h0)
        begin errors++; $display("FAIL d1_empty[%0d] got cnt=%0d af=%b first=%h exp 0 0 0", i, c1, af1, if1.first); end
    end
    checks++; if (e1 !== 1'b0)
      begin errors++; $display("FAIL d1_err got %b exp 0", e1); end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] v;
    bit e, d, exp_rdy, err_m;
    for (int phase = 0; phase < 2; phase++) begin
      apply_reset();
      q.delete();
      err_m = 1'b0;
      for (int n = 0; n < 300; n++) begin
        e = ($urandom_range(0, 99) < 55);
        d = ($urandom_range(0, 99) < 45);
        v = $urandom;
        exp_rdy = (q.size() < 4) || (PASS && d);
        // Phase 0 stays within the protocol; phase 1 lets violations through.
        if (phase == 0) begin
          e = e && exp_rdy;
          d = d && (q.size() > 0);
          exp_rdy = (q.size() < 4) || (PASS && d);
        end
        if4.enq_ena = e; if4.enq_v = v; if4.deq_ena = d;
        #1;
        checks++; if (if4.enq_rdy !== exp_rdy || if4.deq_rdy !== (q.size() > 0))
          begin errors++; $display("FAIL rand_rdy[%0d] got enq=%b deq=%b exp %b %b",
            n, if4.enq_rdy, if4.deq_rdy, exp_rdy, (q.size() > 0)); end
        if ((e && !exp_rdy) || (d && q.size() == 0)) err_m = 1'b1;
        if (d && q.size() > 0) void'(q.pop_front());
        if (e && exp_rdy) q.push_back(v);
        @(posedge CLK);
        @(negedge CLK);
        idle_all();
        #1;
        checks++; if (int'(c4) !== q.size() || af4 !== (q.size() >= 3) || e4 !== err_m)
          begin errors++; $display("FAIL rand_state[%0d] got cnt=%0d af=%b err=%b exp %0d %b %b",
            n, c4, af4, e4, q.size(), (q.size() >= 3), err_m); end
        checks++; if (if4.first !== ((q.size() > 0) ? q[0] : 32'h0) || if4.first_rdy !== (q.size() > 0))
          begin errors++; $display("FAIL rand_first[%0d] got %h/%b exp %h/%b",
            n, if4.first, if4.first_rdy, (q.size() > 0) ? q[0] : 32'h0, (q.size() > 0)); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_deq_empty();
    test_enq_full();
    test_async_reset();
    test_depth1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
